// File: rtl/span_risk_scan.sv
// rtl/span_risk_scan.sv - register-mapped SPAN scan-risk engine (per-scenario MAC, worst-case loss)
//
// Ports:
//   clk, reset        single clock, asynchronous active-high reset
//   writeData, offset register write data and word address
//   write, read       strobes, both qualified by chipselect
//   readData          registered read data
//   busy, done        scan running / one-cycle completion pulse
//   scan_risk         max(0, worst scenario sum)
//   worst_scen        index of the worst scenario
module span_risk_scan #(
    parameter int DATA_W = 16,
    parameter int N_POS  = 4,
    parameter int N_SCEN = 16,
    parameter int ACC_W  = 40,
    parameter int ADDR_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         writeData,
    input  logic [ADDR_W-1:0]         offset,
    input  logic                      write,
    input  logic                      read,
    input  logic                      chipselect,
    output logic [DATA_W-1:0]         readData,
    output logic                      busy,
    output logic                      done,
    output logic [ACC_W-1:0]          scan_risk,
    output logic [$clog2(N_SCEN)-1:0] worst_scen
);

    localparam int RA_N = N_POS * N_SCEN;
    localparam int PIW  = $clog2(N_POS);
    localparam int SW   = $clog2(N_SCEN);
    localparam int RIW  = $clog2(RA_N);
    localparam int PW   = 2 * DATA_W;

    localparam logic [ADDR_W-1:0] A_CTRL  = '1;
    localparam logic [ADDR_W-1:0] A_STAT  = A_CTRL - 1'b1;
    localparam logic [ADDR_W-1:0] A_RHI   = A_CTRL - 2'd2;
    localparam logic [ADDR_W-1:0] A_RMID  = A_CTRL - 2'd3;
    localparam logic [ADDR_W-1:0] A_RLO   = A_CTRL - 3'd4;
    localparam logic [ADDR_W-1:0] OFF_RA  = ADDR_W'(N_POS);
    localparam logic [ADDR_W-1:0] OFF_END = ADDR_W'(N_POS + RA_N);
    localparam logic [PIW-1:0]    P_LAST  = PIW'(N_POS - 1);
    localparam logic [SW-1:0]     S_LAST  = SW'(N_SCEN - 1);

    if (ACC_W < 2 * DATA_W + $clog2(N_POS)) begin : g_acc_too_narrow
        $error("span_risk_scan: ACC_W too small for the scenario sum");
    end
    if ((2 ** ADDR_W) - 4 <= N_POS * (N_SCEN + 1)) begin : g_addr_too_narrow
        $error("span_risk_scan: ADDR_W too small for the register map");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINISH} state_t;

    state_t                     state_q, state_d;
    logic [PIW-1:0]             p_q, p_d;
    logic [SW-1:0]              s_q, s_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [ACC_W-1:0]    best_q, best_d;
    logic [SW-1:0]              best_idx_q, best_idx_d;
    logic [ACC_W-1:0]           risk_q, risk_d;
    logic [SW-1:0]              worst_q, worst_d;
    logic                       done_q, done_d;
    logic                       sticky_q, sticky_d;
    logic [DATA_W-1:0]          rdata_q, rdata_d;
    logic signed [DATA_W-1:0]   qty_q [N_POS];
    logic signed [DATA_W-1:0]   ra_q  [RA_N];

    logic                       ctrl_wr;
    logic                       data_wr;
    logic                       busy_w;
    logic [RIW-1:0]             mac_idx;
    logic signed [PW-1:0]       prod;
    logic signed [ACC_W-1:0]    acc_next;

    assign busy_w  = (state_q != S_IDLE);
    assign ctrl_wr = chipselect && write && (offset == A_CTRL);
    assign data_wr = chipselect && write && !busy_w;

    always_comb begin
        state_d    = state_q;
        p_d        = p_q;
        s_d        = s_q;
        acc_d      = acc_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        risk_d     = risk_q;
        worst_d    = worst_q;
        done_d     = 1'b0;
        sticky_d   = sticky_q;
        rdata_d    = rdata_q;

        mac_idx  = RIW'(p_q) * RIW'(N_SCEN) + RIW'(s_q);
        prod     = PW'(qty_q[p_q]) * PW'(ra_q[mac_idx]);
        // p==0 starts a fresh scenario sum; product sign-extends into the accumulator
        acc_next = ((p_q == '0) ? '0 : acc_q) + ACC_W'(prod);

        unique case (state_q)
            S_IDLE: begin
                if (ctrl_wr && writeData[0]) begin
                    state_d = S_ACCUM;
                    p_d     = '0;
                    s_d     = '0;
                end
            end
            S_ACCUM: begin
                acc_d = acc_next;
                if (p_q == P_LAST) begin
                    // strict compare keeps the lowest index on ties
                    if (s_q == '0 || acc_next > best_q) begin
                        best_d     = acc_next;
                        best_idx_d = s_q;
                    end
                    p_d = '0;
                    if (s_q == S_LAST) state_d = S_FINISH;
                    else               s_d = s_q + 1'b1;
                end else begin
                    p_d = p_q + 1'b1;
                end
            end
            S_FINISH: begin
                // first FINISH cycle publishes the result, second returns to idle
                if (!done_q) begin
                    risk_d   = best_q[ACC_W-1] ? '0 : best_q;
                    worst_d  = best_idx_q;
                    done_d   = 1'b1;
                    sticky_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (busy_w && ctrl_wr && writeData[1]) begin
            state_d  = S_IDLE;
            risk_d   = risk_q;
            worst_d  = worst_q;
            done_d   = 1'b0;
            sticky_d = sticky_q;
        end

        if (chipselect && read) begin
            rdata_d = '0;
            if (offset < OFF_RA) begin
                rdata_d = qty_q[PIW'(offset)];
            end else if (offset < OFF_END) begin
                rdata_d = ra_q[RIW'(offset - OFF_RA)];
            end else if (offset == A_STAT) begin
                rdata_d = DATA_W'({worst_q, busy_w, sticky_q});
                if (!done_d) sticky_d = 1'b0;
            end else if (offset == A_RLO) begin
                rdata_d = DATA_W'(risk_q[15:0]);
            end else if (offset == A_RMID) begin
                rdata_d = DATA_W'(risk_q[31:16]);
            end else if (offset == A_RHI) begin
                rdata_d = DATA_W'(risk_q[ACC_W-1:32]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            p_q        <= '0;
            s_q        <= '0;
            acc_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            risk_q     <= '0;
            worst_q    <= '0;
            done_q     <= 1'b0;
            sticky_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            p_q        <= p_d;
            s_q        <= s_d;
            acc_q      <= acc_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            risk_q     <= risk_d;
            worst_q    <= worst_d;
            done_q     <= done_d;
            sticky_q   <= sticky_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_POS; i++) qty_q[i] <= '0;
            for (int i = 0; i < RA_N; i++)  ra_q[i]  <= '0;
        end else if (data_wr) begin
            if (offset < OFF_RA)        qty_q[PIW'(offset)]           <= writeData;
            else if (offset < OFF_END)  ra_q[RIW'(offset - OFF_RA)]  <= writeData;
        end
    end

    assign readData   = rdata_q;
    assign busy       = busy_w;
    assign done       = done_q;
    assign scan_risk  = risk_q;
    assign worst_scen = worst_q;

endmodule

// File: tb/tb_span_risk_scan.sv
// tb/tb_span_risk_scan.sv - self-checking bench for span_risk_scan
module tb_span_risk_scan;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] writeData = '0;
    logic [7:0]  offset = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        chipselect = 1'b0;
    logic [15:0] readData;
    logic        busy;
    logic        done;
    logic [39:0] scan_risk;
    logic [3:0]  worst_scen;

    int total = 0;
    int bad   = 0;
    int done_seen = 0;

    span_risk_scan dut (
        .clk(clk), .reset(reset), .writeData(writeData), .offset(offset),
        .write(write), .read(read), .chipselect(chipselect), .readData(readData),
        .busy(busy), .done(done), .scan_risk(scan_risk), .worst_scen(worst_scen)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_seen++;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        offset = a; writeData = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [15:0] d);
        offset = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        d = readData;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic prog_t1();
        wr(8'd0, 16'd2);
        wr(8'd1, 16'hFFFF);
        for (int s = 0; s < 16; s++) begin
            wr(8'(4 + s), 16'(s));
            wr(8'(20 + s), 16'd2);
        end
    endtask

    task automatic prog_t3();
        wr(8'd0, 16'd1);
        wr(8'd7, 16'd100);
        wr(8'd13, 16'd100);
    endtask

    // start a scan and follow it to idle; returns edge of done, busy cycles, done pulses
    task automatic run_scan(output int done_edge, output int busy_cnt, output int pulses);
        done_edge = -1; busy_cnt = 0; pulses = 0;
        wr(8'hFF, 16'h0001);
        for (int i = 1; i <= 200; i++) begin
            if (busy) busy_cnt++;
            else break;
            @(negedge clk);
            if (done) begin
                pulses++;
                if (done_edge < 0) done_edge = i;
            end
        end
    endtask

    initial begin
        int de, bc, np, d0;
        logic [15:0] r;
        int nz;

        vecs[0]  = '{8'd251, 16'd28};
        vecs[1]  = '{8'd252, 16'd0};
        vecs[2]  = '{8'd253, 16'd0};
        vecs[3]  = '{8'd0,   16'd2};
        vecs[4]  = '{8'd1,   16'hFFFF};
        vecs[5]  = '{8'd9,   16'd5};
        vecs[6]  = '{8'd23,  16'd2};
        vecs[7]  = '{8'd255, 16'd0};
        vecs[8]  = '{8'd200, 16'd0};
        vecs[9]  = '{8'd254, 16'h003D};
        vecs[10] = '{8'd254, 16'h003C};
        vecs[11] = '{8'd68,  16'd0};

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_risk", scan_risk, 0);
        chk("rst_worst", worst_scen, 0);
        chk("rst_rdata", readData, 0);
        @(negedge clk);
        reset = 1'b0;

        // test 1
        prog_t1();
        run_scan(de, bc, np);
        chk("t1_done_edge", de, 65);
        chk("t1_busy_cycles", bc, 66);
        chk("t1_pulses", np, 1);
        chk("t1_risk", scan_risk, 28);
        chk("t1_worst", worst_scen, 15);
        for (int i = 0; i < 12; i++) begin
            rd(vecs[i].addr, r);
            chk($sformatf("t1_rdvec%0d", i), r, vecs[i].exp);
        end

        // test 2
        do_reset();
        wr(8'd0, 16'd1);
        for (int s = 0; s < 16; s++) wr(8'(4 + s), 16'hFFFB);
        run_scan(de, bc, np);
        chk("t2_risk", scan_risk, 0);
        chk("t2_worst", worst_scen, 0);

        // test 3
        do_reset();
        prog_t3();
        run_scan(de, bc, np);
        chk("t3_risk", scan_risk, 100);
        chk("t3_worst", worst_scen, 3);
        rd(8'd254, r);
        chk("t3_status1", r, 16'h000D);
        rd(8'd254, r);
        chk("t3_status2", r, 16'h000C);

        // test 4
        do_reset();
        prog_t1();
        run_scan(de, bc, np);
        chk("t4_first_risk", scan_risk, 28);
        d0 = done_seen;
        wr(8'hFF, 16'h0001);
        repeat (3) @(negedge clk);
        wr(8'd0, 16'd7);
        repeat (3) @(negedge clk);
        chk("t4_busy_before_abort", busy, 1);
        wr(8'hFF, 16'h0002);
        chk("t4_busy_after_abort", busy, 0);
        repeat (80) @(negedge clk);
        chk("t4_no_done", done_seen, d0);
        chk("t4_risk_kept", scan_risk, 28);
        chk("t4_worst_kept", worst_scen, 15);
        rd(8'd0, r);
        chk("t4_qty0", r, 2);
        run_scan(de, bc, np);
        chk("t4_restart_risk", scan_risk, 28);
        chk("t4_restart_pulses", np, 1);

        // test 5
        do_reset();
        for (int p = 0; p < 4; p++) wr(8'(p), 16'h8000);
        for (int i = 0; i < 64; i++) wr(8'(4 + i), 16'h8000);
        run_scan(de, bc, np);
        chk("t5_risk", scan_risk, 40'h01_0000_0000);
        chk("t5_worst", worst_scen, 0);
        rd(8'd251, r); chk("t5_rlo", r, 16'h0000);
        rd(8'd252, r); chk("t5_rmid", r, 16'h0000);
        rd(8'd253, r); chk("t5_rhi", r, 16'h0001);

        // test 6
        do_reset();
        prog_t1();
        run_scan(de, bc, np);
        rd(8'd0, r);
        chk("t6_pre_rdata", r, 2);
        wr(8'hFF, 16'h0001);
        repeat (29) @(negedge clk);
        chk("t6_busy_mid", busy, 1);
        reset = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_rdata", readData, 0);
        chk("t6_risk", scan_risk, 0);
        chk("t6_worst", worst_scen, 0);
        @(negedge clk);
        reset = 1'b0;
        nz = 0;
        for (int a = 0; a < 68; a++) begin
            rd(8'(a), r);
            if (r != 0) nz++;
        end
        for (int a = 251; a < 256; a++) begin
            rd(8'(a), r);
            if (r != 0) nz++;
        end
        chk("t6_regs_zero", nz, 0);
        prog_t3();
        run_scan(de, bc, np);
        chk("t6_risk_after", scan_risk, 100);
        chk("t6_worst_after", worst_scen, 3);
        chk("t6_done_edge", de, 65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
